register_bank: RTL and testbench
================================

REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 The block SHALL be parameterised as follows.
- WIDTH, default 8: register and data width in bits, minimum 2.
- DEPTH, default 4: number of registers, minimum 2.
- AW, default $clog2(DEPTH): address width.

REQ-002 The block SHALL have these ports; reset is synchronous and active-low, and clock is clk.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-low reset.
- load_n  input  1  active-low write strobe.
- wr_addr  input  AW  target register.
- op  input  3  operation select.
- data_in  input  WIDTH  load data.
- rd_addr_a  input  AW  read port A address.
- rd_data_a  output  WIDTH  read port A data.
- rd_addr_b  input  AW  read port B address.
- rd_data_b  output  WIDTH  read port B data.
- carry  output  1  carry/borrow/shifted-out bit of the last executed op.
- zero  output  1  high when the last executed op's result was zero.
- err  output  1  one-cycle pulse flagging an out-of-range access.

Function
REQ-003 The block SHALL execute an op on a rising edge only when reset=1 and load_n=0; with load_n=1, registers and carry/zero SHALL hold.
REQ-004 The op encoding SHALL be as follows; every result is written back to R[wr_addr].
- 000 LOAD: R=data_in.
- 001 INC: R=R+1.
- 010 DEC: R=R-1.
- 011 SHL: R<<1, 0 shifted in.
- 100 SHR: R>>1, 0 shifted in.
- 101 CLR: R=0.
- 110 ROL: rotate left by 1.
- 111 HOLD: no change.
REQ-005 Arithmetic SHALL be modulo 2^WIDTH: INC of all-ones gives 0, and DEC of 0 gives all-ones.
REQ-006 The carry register SHALL be updated by each executed op as follows.
- LOAD, CLR: 0.
- INC: 1 iff old value was all-ones.
- DEC: 1 iff old value was 0.
- SHL, ROL: old MSB.
- SHR: old LSB.
REQ-007 The zero register SHALL be updated by each executed op (except HOLD) to 1 iff the result written is 0.
REQ-008 HOLD SHALL leave all registers, carry and zero unchanged.
REQ-009 rd_data_a and rd_data_b SHALL be combinational functions of the current register contents, valid in the same cycle the address is applied.
REQ-010 Reading a register in the cycle it is written SHALL return the old value; the new value SHALL appear after that rising edge.
REQ-011 Both read ports SHALL be usable simultaneously on the same or different addresses.
REQ-012 A read address >= DEPTH SHALL return 0 on that port.
REQ-013 A write with wr_addr >= DEPTH SHALL modify no register and leave carry/zero unchanged.
REQ-014 Such an out-of-range write SHALL also set err=1 for exactly the following cycle.
REQ-015 err SHALL be 0 in every cycle not following an out-of-range write.
REQ-016 At most one register SHALL change per clock edge; other registers SHALL be unaffected.

Reset
REQ-017 When reset=0 at a rising edge, all registers SHALL become 0, and carry=0, zero=0, err=0, regardless of load_n, op or addresses.
REQ-018 Reset SHALL take priority over a write in the same cycle.
REQ-019 A reset asserted between two writes of a sequence SHALL discard any earlier results; no write SHALL be pending across reset.
REQ-020 The first write SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-021 The bench SHALL cover the following directed scenarios; all use WIDTH=8, DEPTH=4 except where stated.
- Reset, then read all addresses on both ports -> every read returns 0x00; carry=0, zero=0, err=0.
- LOAD 0xFF to R2, then INC R2 -> R2=0x00, carry=1, zero=1; a read of R2 during the INC cycle returns 0xFF.
- LOAD 0x81 to R1, then SHL, SHR, ROL in sequence -> after SHL R1=0x02, carry=1; after SHR R1=0x01, carry=0; after ROL R1=0x02, carry=0; zero stays 0.
- DEC R0 from 0x00 -> R0=0xFF, carry=1, zero=0; then HOLD -> R0, carry and zero unchanged.
- DEPTH=3: write with wr_addr=3 -> no register changes, err=1 for one cycle then 0; read address 3 returns 0x00.
- load_n=0 and reset=0 together with LOAD 0x55 to R1 -> R1=0x00; next cycle with reset=1, LOAD 0x55 -> R1=0x55.

Source files
------------

// File: rtl/register_bank.sv
// register_bank: small register file with a single-port ALU write path
// (load/inc/dec/shift/rotate/clear) and two combinational read ports.
module register_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_n,
  input  logic [AW-1:0]    wr_addr,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    rd_addr_a,
  output logic [WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             carry,
  output logic             zero,
  output logic             err
);
  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_INC  = 3'b001;
  localparam logic [2:0] OP_DEC  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_SHR  = 3'b100;
  localparam logic [2:0] OP_CLR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_HOLD = 3'b111;
  localparam logic [AW:0] LIM    = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] cur, res;
  logic             c_nxt, wr_ok;
  assign wr_ok     = {1'b0, wr_addr} < LIM;
  assign cur       = wr_ok ? regs[wr_addr] : '0;
  assign rd_data_a = ({1'b0, rd_addr_a} < LIM) ? regs[rd_addr_a] : '0;
  assign rd_data_b = ({1'b0, rd_addr_b} < LIM) ? regs[rd_addr_b] : '0;
  always_comb begin
    res   = cur;
    c_nxt = carry;
    case (op)
      OP_LOAD: begin res = data_in; c_nxt = 1'b0; end
      OP_INC:  begin res = cur + 1'b1; c_nxt = &cur; end
      OP_DEC:  begin res = cur - 1'b1; c_nxt = ~|cur; end
      OP_SHL:  {c_nxt, res} = {cur, 1'b0};
      OP_SHR:  {res, c_nxt} = {1'b0, cur};
      OP_CLR:  begin res = '0; c_nxt = 1'b0; end
      OP_ROL:  begin res = {cur[WIDTH-2:0], cur[WIDTH-1]}; c_nxt = cur[WIDTH-1]; end
      default: begin res = cur; c_nxt = carry; end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      carry <= 1'b0;
      zero  <= 1'b0;
      err   <= 1'b0;
    end else begin
      err <= !load_n && !wr_ok;
      // out-of-range writes and HOLD leave both the array and the flags alone
      if (!load_n && wr_ok && op != OP_HOLD) begin
        regs[wr_addr] <= res;
        carry         <= c_nxt;
        zero          <= res == '0;
      end
    end
  end
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: drives a DEPTH=4 and a DEPTH=3 bank with identical stimulus
// and compares both against an arithmetic reference model.
module tb_register_bank;
  logic clk = 1'b0;
  logic reset, load_n;
  logic [2:0] op;
  logic [1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [7:0] data_in;
  logic [1:0][7:0] rda, rdb;
  logic [1:0] cy, zr, er;
  int tests = 0, fails = 0;
  int m [2][4];
  int mc [2], mz [2], me [2];
  int dep [2] = '{4, 3};

  always #5 clk = ~clk;

  register_bank #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .load_n(load_n), .wr_addr(wr_addr), .op(op),
    .data_in(data_in), .rd_addr_a(rd_addr_a), .rd_data_a(rda[0]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb[0]), .carry(cy[0]), .zero(zr[0]), .err(er[0]));
  register_bank #(.WIDTH(8), .DEPTH(3), .AW(2)) dut3 (
    .clk(clk), .reset(reset), .load_n(load_n), .wr_addr(wr_addr), .op(op),
    .data_in(data_in), .rd_addr_a(rd_addr_a), .rd_data_a(rda[1]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb[1]), .carry(cy[1]), .zero(zr[1]), .err(er[1]));

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rd_model(int k, int a);
    return (a < dep[k]) ? m[k][a] : 0;
  endfunction

  task automatic check_all(input string ph);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_rda_d%0d", ph, dep[k]), rda[k], rd_model(k, rd_addr_a));
      chk($sformatf("%s_rdb_d%0d", ph, dep[k]), rdb[k], rd_model(k, rd_addr_b));
      chk($sformatf("%s_carry_d%0d", ph, dep[k]), cy[k], mc[k]);
      chk($sformatf("%s_zero_d%0d", ph, dep[k]), zr[k], mz[k]);
      chk($sformatf("%s_err_d%0d", ph, dep[k]), er[k], me[k]);
    end
  endtask

  task automatic model_update();
    int old, r, c;
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        for (int i = 0; i < 4; i++) m[k][i] = 0;
        mc[k] = 0; mz[k] = 0; me[k] = 0;
      end else begin
        me[k] = (!load_n && wr_addr >= dep[k]) ? 1 : 0;
        if (!load_n && wr_addr < dep[k] && op != 3'd7) begin
          old = m[k][wr_addr];
          r = old; c = mc[k];
          case (op)
            3'd0: begin r = data_in; c = 0; end
            3'd1: begin r = (old + 1) % 256; c = (old == 255); end
            3'd2: begin r = (old + 255) % 256; c = (old == 0); end
            3'd3: begin r = (old * 2) % 256; c = old / 128; end
            3'd4: begin r = old / 2; c = old % 2; end
            3'd5: begin r = 0; c = 0; end
            3'd6: begin r = (old * 2) % 256 + old / 128; c = old / 128; end
            default: ;
          endcase
          m[k][wr_addr] = r; mc[k] = c; mz[k] = (r == 0);
        end
      end
    end
  endtask

  task automatic step(input logic rs, input logic ld, input logic [2:0] o, input logic [1:0] wa,
                      input logic [7:0] d, input logic [1:0] a, input logic [1:0] b);
    reset = rs; load_n = ld; op = o; wr_addr = wa; data_in = d; rd_addr_a = a; rd_addr_b = b;
    #2;
    check_all("pre");
    model_update();
    @(posedge clk); #1;
    check_all("post");
  endtask

  initial begin
    reset = 1'b0; load_n = 1'b0; op = 3'd0; wr_addr = 2'd1; data_in = 8'hAA;
    rd_addr_a = 2'd0; rd_addr_b = 2'd1;
    repeat (2) @(posedge clk);
    #1;
    model_update();
    for (int a = 0; a < 4; a++) begin
      step(1'b1, 1'b1, 3'd0, 2'd0, 8'h00, 2'(a), 2'(3 - a));
      chk("rst_rd_a", rda[0], 0);
      chk("rst_rd_b", rdb[0], 0);
    end
    chk("rst_flags", {cy[0], zr[0], er[0]}, 0);
    step(1'b1, 1'b0, 3'd0, 2'd2, 8'hFF, 2'd2, 2'd2);
    step(1'b1, 1'b0, 3'd1, 2'd2, 8'h00, 2'd2, 2'd0);
    chk("inc_wrap", rda[0], 8'h00);
    chk("inc_carry", cy[0], 1);
    chk("inc_zero", zr[0], 1);
    step(1'b1, 1'b0, 3'd0, 2'd1, 8'h81, 2'd1, 2'd1);
    step(1'b1, 1'b0, 3'd3, 2'd1, 8'h00, 2'd1, 2'd1);
    chk("shl_val", rda[0], 8'h02);
    chk("shl_carry", cy[0], 1);
    step(1'b1, 1'b0, 3'd4, 2'd1, 8'h00, 2'd1, 2'd1);
    chk("shr_val", rda[0], 8'h01);
    chk("shr_carry", cy[0], 0);
    step(1'b1, 1'b0, 3'd6, 2'd1, 8'h00, 2'd1, 2'd1);
    chk("rol_val", rda[0], 8'h02);
    chk("rol_carry", cy[0], 0);
    chk("rol_zero", zr[0], 0);
    step(1'b1, 1'b0, 3'd2, 2'd0, 8'h00, 2'd0, 2'd0);
    chk("dec_wrap", rda[0], 8'hFF);
    chk("dec_flags", {cy[0], zr[0]}, 2'b10);
    step(1'b1, 1'b0, 3'd7, 2'd0, 8'h12, 2'd0, 2'd0);
    chk("hold_val", rda[0], 8'hFF);
    chk("hold_flags", {cy[0], zr[0]}, 2'b10);
    step(1'b1, 1'b0, 3'd0, 2'd3, 8'h12, 2'd3, 2'd2);
    chk("oor_err", er[1], 1);
    chk("oor_rd", rda[1], 0);
    chk("oor_r2", rdb[1], 8'h00);
    step(1'b1, 1'b1, 3'd0, 2'd3, 8'h12, 2'd3, 2'd0);
    chk("oor_err_clr", er[1], 0);
    step(1'b0, 1'b0, 3'd0, 2'd1, 8'h55, 2'd1, 2'd0);
    chk("rst_prio", rda[0], 0);
    step(1'b1, 1'b0, 3'd0, 2'd1, 8'h55, 2'd1, 2'd0);
    chk("first_write", rda[0], 8'h55);
    for (int i = 0; i < 400; i++)
      step(($urandom % 20) != 0, ($urandom % 4) == 0, 3'($urandom), 2'($urandom),
           8'($urandom), 2'($urandom), 2'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
